// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
// Frame state encoding, data width and parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS = 8;

  function automatic logic odd_parity_ok(
    input logic [PS2_DATA_BITS-1:0] d,
    input logic                     p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small synchronous FIFO with valid/ready read side.
// A push into a full FIFO succeeds only with a same-cycle pop.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_wr;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_pop   = o_valid & i_ready;
  assign w_wr    = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM,
// inter-bit timeout and buffered byte output with overflow flag.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_timeout,
  output logic                          o_overflow,
  input  logic                          i_err_clr
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    w_pin;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clk_q;
  logic          w_fall;
  logic          w_bit;

  assign w_pin  = {ps2_dat, ps2_clk};
  assign w_fall = r_clk_q & ~r_filt[0];
  assign w_bit  = r_filt[1];

  // Index 0 is the clock pin, index 1 the data pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta    <= '1;
      r_sync    <= '1;
      r_filt    <= '1;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
      r_clk_q   <= 1'b1;
    end else begin
      r_meta  <= w_pin;
      r_sync  <= r_meta;
      r_clk_q <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FMAX) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  ps2_rx_state_t            r_state, w_state_n;
  logic [2:0]               r_bitcnt, w_bitcnt_n;
  logic [PS2_DATA_BITS-1:0] r_shift, w_shift_n;
  logic                     r_par, w_par_n;
  logic [TW-1:0]            r_tcnt, w_tcnt_n;
  logic                     r_push, w_push_n;
  logic                     r_perr, w_perr_n;
  logic                     r_ferr, w_ferr_n;
  logic                     r_to, w_to_n;
  logic                     r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
      r_push   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_tcnt   <= w_tcnt_n;
      r_push   <= w_push_n;
      r_perr   <= w_perr_n;
      r_ferr   <= w_ferr_n;
      r_to     <= w_to_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_n    = r_par;
    w_tcnt_n   = r_tcnt;
    w_push_n   = 1'b0;
    w_perr_n   = 1'b0;
    w_ferr_n   = 1'b0;
    w_to_n     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_n  = DATA;
          w_bitcnt_n = '0;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_n  = {w_bit, r_shift[PS2_DATA_BITS-1:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) w_state_n = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_n   = w_bit;
          w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_n = IDLE;
          if (!w_bit) w_ferr_n = 1'b1;
          else if (!odd_parity_ok(r_shift, r_par)) w_perr_n = 1'b1;
          else w_push_n = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    if (r_state == IDLE || w_fall) begin
      w_tcnt_n = '0;
    end else if (r_tcnt == TMAX) begin
      w_tcnt_n  = '0;
      w_to_n    = 1'b1;
      w_state_n = IDLE;
    end else begin
      w_tcnt_n = r_tcnt + 1'b1;
    end
  end

  logic w_full;
  logic w_pop;
  logic w_drop;

  assign w_pop  = o_valid & i_ready;
  assign w_drop = r_push & w_full & ~w_pop;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
    else if (i_err_clr) r_ovf <= 1'b0;
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_push),
    .i_data  (r_shift),
    .o_full  (w_full),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_timeout    = r_to;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames
// checked against a frame-level model of expected bytes and events.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int H     = 40;
  localparam int DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       i_ready = 1'b0;
  logic       i_err_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_timeout;
  logic       o_overflow;

  ps2_rx_fifo dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_timeout    (o_timeout),
    .o_overflow   (o_overflow),
    .i_err_clr    (i_err_clr)
  );

  always #10 i_clk = ~i_clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  byte unsigned q[$];
  int  exp_perr = 0, exp_ferr = 0, exp_to = 0;
  logic exp_ovf = 1'b0;
  int  cyc_perr = 0, cyc_ferr = 0, cyc_to = 0;
  bit  rnd_ready = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      cyc_perr += int'(o_parity_err);
      cyc_ferr += int'(o_frame_err);
      cyc_to   += int'(o_timeout);
      if (prev_hold && o_valid) chk("hold", o_data, prev_data);
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("extra_pop", o_valid, 1'b0);
        else chk("pop", o_data, q.pop_front());
      end
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame(input logic [7:0] d, input int kind);
    logic par;
    logic stp;
    par = (kind == 1) ? ^d : ~^d;
    stp = (kind != 2);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n, input bit gl);
    for (int i = 0; i < n; i++) begin
      ps2_dat = b[i];
      if (gl && i >= 2 && i <= 6) begin
        tick(10); ps2_clk = 1'b0; tick(7); ps2_clk = 1'b1; tick(H - 17);
      end else tick(H);
      ps2_clk = 1'b0;
      if (gl && i >= 2 && i <= 6) begin
        tick(10); ps2_clk = 1'b1; tick(7); ps2_clk = 1'b0; tick(H - 17);
      end else tick(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(H);
  endtask

  task automatic send_frame(input logic [7:0] d, input int kind, input bit gl);
    if (kind == 2) exp_ferr++;
    else if (kind == 1) exp_perr++;
    else if (q.size() >= DEPTH) exp_ovf = 1'b1;
    else q.push_back(d);
    send_bits(frame(d, kind), 11, gl);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && q.size() != 0; i++) tick(1);
    chk({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_perr"}, cyc_perr, exp_perr);
    chk({tag, "_ferr"}, cyc_ferr, exp_ferr);
    chk({tag, "_tmo"}, cyc_to, exp_to);
    chk({tag, "_ovf"}, o_overflow, exp_ovf);
  endtask

  initial begin
    tick(5);
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_count", o_count, 3'd0);
    chk("rst_perr", o_parity_err, 1'b0);
    chk("rst_ferr", o_frame_err, 1'b0);
    chk("rst_tmo", o_timeout, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    i_rst_n = 1'b1;
    tick(20);

    i_ready = 1'b1;
    send_frame(8'h55, 0, 1'b0);
    send_frame(8'h66, 0, 1'b0);
    send_frame(8'h77, 0, 1'b0);
    drain("good");
    check_state("good");

    send_frame(8'hAA, 1, 1'b0);
    tick(20);
    chk("par_count", o_count, 3'd0);
    check_state("par");

    send_frame(8'h88, 2, 1'b0);
    tick(20);
    chk("frm_count", o_count, 3'd0);
    send_frame(8'h99, 0, 1'b0);
    drain("frm");
    check_state("frm");

    exp_to++;
    send_bits(frame(8'hBB, 0), 5, 1'b0);
    tick(10100);
    send_frame(8'hCC, 0, 1'b0);
    drain("tmo");
    check_state("tmo");

    i_ready = 1'b0;
    send_frame(8'h11, 0, 1'b0);
    send_frame(8'h22, 0, 1'b0);
    send_frame(8'h33, 0, 1'b0);
    send_frame(8'h44, 0, 1'b0);
    send_frame(8'h55, 0, 1'b0);
    tick(20);
    chk("ovf_count", o_count, 3'd4);
    chk("ovf_valid", o_valid, 1'b1);
    chk("ovf_head", o_data, 8'h11);
    chk("ovf_flag", o_overflow, exp_ovf);
    i_ready = 1'b1;
    drain("ovf");
    chk("ovf_sticky", o_overflow, exp_ovf);
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    exp_ovf = 1'b0;
    tick(1);
    chk("ovf_clr", o_overflow, exp_ovf);

    send_frame(8'hDD, 0, 1'b1);
    drain("glitch");
    check_state("glitch");

    send_bits(frame(8'hDD, 0), 4, 1'b0);
    i_rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_count", o_count, 3'd0);
    chk("mid_rst_tmo", o_timeout, 1'b0);
    tick(3);
    i_rst_n = 1'b1;
    tick(H);
    send_frame(8'hDD, 0, 1'b0);
    drain("post_rst");
    check_state("post_rst");

    rnd_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int r;
      int kind;
      d = 8'($urandom);
      r = int'($urandom_range(0, 9));
      kind = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      send_frame(d, kind, ($urandom_range(0, 3) == 0));
    end
    rnd_ready = 1'b0;
    tick(1);
    i_ready = 1'b1;
    drain("rand");
    tick(20);
    check_state("rand");
    chk("end_count", o_count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
